// File: rtl/wptr_full_lvl.sv
// ============================================================================
// Module   : wptr_full_lvl
// Brief    : Async-FIFO write-side pointer, full / almost-full / level generator.
//            Optional sticky overflow flag enabled by macro WPTR_OVF_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wptr_full_lvl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   wafull_thresh,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_ptr;
  logic              r_full;
  logic              r_afull;
  logic [ADDRSIZE:0] r_level;

  logic              w_inc;
  logic [ADDRSIZE:0] w_binnext;
  logic [ADDRSIZE:0] w_graynext;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_diff;
  logic              w_full_val;
  logic              w_afull_val;

  assign w_inc      = winc & ~r_full;
  assign w_binnext  = r_bin + {{ADDRSIZE{1'b0}}, w_inc};
  assign w_graynext = (w_binnext >> 1) ^ w_binnext;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
      assign w_rbin[gi] = ^wq2_rptr[ADDRSIZE:gi];
    end
  endgenerate

  assign w_diff      = w_binnext - w_rbin;
  assign w_full_val  = (w_graynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                        wq2_rptr[ADDRSIZE-2:0]});
  assign w_afull_val = (wafull_thresh != '0) && (w_diff >= wafull_thresh);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_bin   <= '0;
      r_ptr   <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
    end else begin
      r_bin   <= w_binnext;
      r_ptr   <= w_graynext;
      r_full  <= w_full_val;
      r_afull <= w_afull_val;
      r_level <= w_diff;
    end
  end

`ifdef WPTR_OVF_ERR_EN
  logic r_ovf;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_ovf <= 1'b0;
    end else if (winc && r_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign wovf = r_ovf;
`else
  assign wovf = 1'b0;
`endif

  assign waddr  = r_bin[ADDRSIZE-1:0];
  assign wptr   = r_ptr;
  assign wfull  = r_full;
  assign wafull = r_afull;
  assign wlevel = r_level;

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_lvl.sv
// ============================================================================
// Module   : tb_wptr_full_lvl
// Brief    : Directed self-checking bench for wptr_full_lvl at ADDRSIZE=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wptr_full_lvl;

  localparam int ADDRSIZE = 4;
`ifdef WPTR_OVF_ERR_EN
  localparam logic c_OVF_EXP = 1'b1;
`else
  localparam logic c_OVF_EXP = 1'b0;
`endif

  logic                wclk = 1'b0;
  logic                wrst;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wafull_thresh;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  int n_checks = 0;
  int n_fail   = 0;

  wptr_full_lvl #(.ADDRSIZE(ADDRSIZE)) u_dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .winc          (winc),
    .wq2_rptr      (wq2_rptr),
    .wafull_thresh (wafull_thresh),
    .waddr         (waddr),
    .wptr          (wptr),
    .wfull         (wfull),
    .wafull        (wafull),
    .wlevel        (wlevel),
    .wovf          (wovf)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [ADDRSIZE:0] gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  initial begin
    logic [ADDRSIZE:0] mb;
    logic [ADDRSIZE:0] rb;
    logic [ADDRSIZE:0] prev;

    wrst = 1'b1; winc = 1'b1; wq2_rptr = '0; wafull_thresh = 5'd12;

    // Reset held three cycles with write requests present
    repeat (3) tick();
    check("rst_waddr",  waddr,  0);
    check("rst_wptr",   wptr,   0);
    check("rst_wfull",  wfull,  0);
    check("rst_wafull", wafull, 0);
    check("rst_wlevel", wlevel, 0);
    check("rst_wovf",   wovf,   0);

    // Fill sixteen entries
    wrst = 1'b0; winc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 11) begin
        check("fill11_wafull", wafull, 0);
        check("fill11_wlevel", wlevel, 11);
      end
      if (k == 12) begin
        check("fill12_wafull", wafull, 1);
        check("fill12_wlevel", wlevel, 12);
      end
      if (k == 15) check("fill15_wfull", wfull, 0);
    end
    check("fill16_wfull",  wfull,  1);
    check("fill16_wptr",   wptr,   5'b11000);
    check("fill16_wlevel", wlevel, 16);
    check("fill16_waddr",  waddr,  0);
    check("fill16_wovf",   wovf,   0);

    // Writes while full are dropped
    repeat (2) tick();
    winc = 1'b0;
    check("ovf_wptr",   wptr,   5'b11000);
    check("ovf_waddr",  waddr,  0);
    check("ovf_wlevel", wlevel, 16);
    check("ovf_wfull",  wfull,  1);
    check("ovf_wovf",   wovf,   c_OVF_EXP);

    // Drain: one read releases full, five reads release almost-full
    wq2_rptr = 5'b00001;
    tick();
    check("drain1_wfull",  wfull,  0);
    check("drain1_wlevel", wlevel, 15);
    check("drain1_wafull", wafull, 1);
    check("drain1_wovf",   wovf,   c_OVF_EXP);
    wq2_rptr = 5'b00111;
    tick();
    check("drain5_wlevel", wlevel, 11);
    check("drain5_wafull", wafull, 0);

    // Lockstep write and read across the pointer wrap
    mb = 5'd16; rb = 5'd5; winc = 1'b1;
    for (int s = 0; s < 18; s++) begin
      prev = wptr;
      rb = rb + 5'd1;
      wq2_rptr = gray(rb);
      tick();
      mb = mb + 5'd1;
      check("wrap_wptr",   wptr,   gray(mb));
      check("wrap_waddr",  waddr,  mb[ADDRSIZE-1:0]);
      check("wrap_onebit", $countones(prev ^ wptr), 1);
      check("wrap_wlevel", wlevel, 11);
      check("wrap_wfull",  wfull,  0);
      if (mb == 5'd0) begin
        check("wrap_prev31", prev, 5'b10000);
        check("wrap_zero",   wptr, 5'b00000);
      end
    end

    // Bring level to 9, then reset with a write pending
    winc = 1'b0;
    wq2_rptr = gray(5'd24); tick();
    wq2_rptr = gray(5'd25); tick();
    check("pre_rst_wlevel", wlevel, 9);
    wrst = 1'b1; winc = 1'b1;
    tick();
    check("mid_rst_waddr",  waddr,  0);
    check("mid_rst_wptr",   wptr,   0);
    check("mid_rst_wfull",  wfull,  0);
    check("mid_rst_wafull", wafull, 0);
    check("mid_rst_wlevel", wlevel, 0);
    check("mid_rst_wovf",   wovf,   0);

    // Resume from address 0; threshold 1 then disabled with 0
    wrst = 1'b0; wq2_rptr = '0; wafull_thresh = 5'd1;
    tick();
    check("resume_waddr",  waddr,  1);
    check("resume_wptr",   wptr,   5'b00001);
    check("resume_wlevel", wlevel, 1);
    check("resume_wafull", wafull, 1);
    winc = 1'b0; wafull_thresh = 5'd0;
    tick();
    check("thr0_wafull", wafull, 0);
    check("thr0_wlevel", wlevel, 1);

    // Threshold above depth never asserts, even when full
    wafull_thresh = 5'd17; winc = 1'b1;
    repeat (15) tick();
    winc = 1'b0;
    check("thr17_wfull",  wfull,  1);
    check("thr17_wlevel", wlevel, 16);
    check("thr17_wafull", wafull, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
